// File: rtl/dp64_seq_ctrl_if.sv
// Operand-beat and result handshake bundle for dp64_seq_ctrl.
interface dp64_seq_ctrl_if #(
    parameter int ACC_W = 48
);
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      a;
    logic [63:0]      b;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
    logic             overflow;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, acc_out, overflow
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, acc_out, overflow
    );
endinterface

// File: rtl/dp64_seq_ctrl.sv
// Streaming vector dot-product sequencer around the combinational dp64 lane multiplier.
// Build option DP_SAT_EN: accumulator saturates on overflow instead of wrapping.

// Unsigned lane-wise dot product of one 64-bit word pair at each precision.
module dp64 (
    input  logic [63:0] i_a,
    input  logic [63:0] i_b,
    output logic [34:0] o_sum16,
    output logic [18:0] o_sum8,
    output logic [11:0] o_sum4,
    output logic [10:0] o_sum2
);
    always_comb begin
        o_sum16 = '0;
        o_sum8  = '0;
        o_sum4  = '0;
        o_sum2  = '0;
        for (int i = 0; i < 4; i++)
            o_sum16 = o_sum16 + {19'd0, i_a[16*i +: 16]} * {19'd0, i_b[16*i +: 16]};
        for (int i = 0; i < 8; i++)
            o_sum8 = o_sum8 + {11'd0, i_a[8*i +: 8]} * {11'd0, i_b[8*i +: 8]};
        for (int i = 0; i < 16; i++)
            o_sum4 = o_sum4 + {8'd0, i_a[4*i +: 4]} * {8'd0, i_b[4*i +: 4]};
        for (int i = 0; i < 32; i++)
            o_sum2 = o_sum2 + {9'd0, i_a[2*i +: 2]} * {9'd0, i_b[2*i +: 2]};
    end
endmodule

// state | meaning
// IDLE  | waiting for start; last result held on acc_out
// RUN   | accepting operand beats until len have been taken
// DRAIN | last beat in the pipeline register, accumulator not yet updated
// DONE  | result presented until out_valid & out_ready
module dp64_seq_ctrl #(
    parameter int ACC_W = 48,
    parameter int LEN_W = 16
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  logic             i_start,
    input  logic [1:0]       i_mode,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_busy,
    dp64_seq_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_mode;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic [63:0]      r_a;
    logic [63:0]      r_b;
    logic             r_stg_vld;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;

    logic             w_start_job;
    logic             w_accept;
    logic             w_last;
    logic             w_carry;
    logic [34:0]      w_sum16;
    logic [18:0]      w_sum8;
    logic [11:0]      w_sum4;
    logic [10:0]      w_sum2;
    logic [ACC_W-1:0] w_sel;
    logic [ACC_W:0]   w_add;

    dp64 u_dp64 (
        .i_a     (r_a),
        .i_b     (r_b),
        .o_sum16 (w_sum16),
        .o_sum8  (w_sum8),
        .o_sum4  (w_sum4),
        .o_sum2  (w_sum2)
    );

    assign w_start_job = i_start && (r_state == S_IDLE);
    assign w_accept    = bus.in_valid && bus.in_ready;
    assign w_last      = (r_cnt == r_len - LEN_W'(1));

    always_comb begin
        w_sel = '0;
        case (r_mode)
            2'd0:    w_sel = ACC_W'(w_sum16);
            2'd1:    w_sel = ACC_W'(w_sum8);
            2'd2:    w_sel = ACC_W'(w_sum4);
            default: w_sel = ACC_W'(w_sum2);
        endcase
    end

    // One extra bit so the carry out of the accumulator is visible.
    assign w_add   = {1'b0, r_acc} + {1'b0, w_sel};
    assign w_carry = w_add[ACC_W];

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        o_busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) w_state_nxt = (i_len != '0) ? S_RUN : S_DONE;
            end
            S_RUN: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid && w_last) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: w_state_nxt = S_DONE;
            S_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_mode    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_stg_vld <= 1'b0;
            r_acc     <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_stg_vld <= w_accept;
            if (w_accept) begin
                r_a   <= bus.a;
                r_b   <= bus.b;
                r_cnt <= r_cnt + LEN_W'(1);
            end
            if (w_start_job) begin
                r_mode <= i_mode;
                r_len  <= i_len;
                r_cnt  <= '0;
                r_acc  <= '0;
                r_ovf  <= 1'b0;
            end else if (r_stg_vld) begin
                if (w_carry) r_ovf <= 1'b1;
`ifdef DP_SAT_EN
                // Once saturated, the accumulator is pinned for the rest of the job.
                r_acc <= (w_carry || r_ovf) ? '1 : w_add[ACC_W-1:0];
`else
                r_acc <= w_add[ACC_W-1:0];
`endif
            end
        end
    end

    assign bus.acc_out  = r_acc;
    assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_dp64_seq_ctrl.sv
// Bench for dp64_seq_ctrl: a 48-bit and a 36-bit instance run in lockstep on the same stimulus.
module tb_dp64_seq_ctrl;
    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = '0;
    logic [15:0] len = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        busy48;
    logic        busy36;

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] beat_a[$];
    logic [63:0] beat_b[$];

    typedef struct {
        logic [1:0]  mode;
        int          len;
        logic [63:0] pa;
        logic [63:0] pb;
        int          gap;
        int          hold;
        logic [63:0] e48;
        logic        o48;
        logic [63:0] e36;
        logic        o36;
    } vec_t;
    vec_t tbl[6];

    dp64_seq_ctrl_if #(.ACC_W(48)) bus48();
    dp64_seq_ctrl_if #(.ACC_W(36)) bus36();

    assign bus48.in_valid  = in_valid;
    assign bus48.a         = a;
    assign bus48.b         = b;
    assign bus48.out_ready = out_ready;
    assign bus36.in_valid  = in_valid;
    assign bus36.a         = a;
    assign bus36.b         = b;
    assign bus36.out_ready = out_ready;

    dp64_seq_ctrl #(.ACC_W(48), .LEN_W(16)) u_dut (
        .i_clk(clk), .i_nrst(nrst), .i_start(start), .i_mode(mode), .i_len(len),
        .o_busy(busy48), .bus(bus48)
    );
    dp64_seq_ctrl #(.ACC_W(36), .LEN_W(16)) u_dut36 (
        .i_clk(clk), .i_nrst(nrst), .i_start(start), .i_mode(mode), .i_len(len),
        .o_busy(busy36), .bus(bus36)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: true unsigned lane-wise dot product at lane width 16 >> mode.
    function automatic logic [63:0] lane_dot(input logic [1:0] m, input logic [63:0] x,
                                             input logic [63:0] y);
        int w;
        logic [63:0] msk;
        logic [63:0] s;
        w   = 16 >> m;
        msk = (64'd1 << w) - 64'd1;
        s   = '0;
        for (int i = 0; i < 64 / w; i++)
            s += ((x >> (i * w)) & msk) * ((y >> (i * w)) & msk);
        return s;
    endfunction

    function automatic logic [63:0] exp_acc(input logic [63:0] tot, input int w);
        logic [63:0] lim;
        lim = (64'd1 << w) - 64'd1;
        if (tot <= lim) return tot;
`ifdef DP_SAT_EN
        return lim;
`else
        return tot & lim;
`endif
    endfunction

    function automatic logic exp_ovf(input logic [63:0] tot, input int w);
        return tot >= (64'd1 << w);
    endfunction

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"},      64'(busy48),           64'd0);
        chk({tag, "_in_ready"},  64'(bus48.in_ready),   64'd0);
        chk({tag, "_out_valid"}, 64'(bus48.out_valid),  64'd0);
        chk({tag, "_acc_out"},   64'(bus48.acc_out),    64'd0);
        chk({tag, "_overflow"},  64'(bus48.overflow),   64'd0);
        chk({tag, "_acc36"},     64'(bus36.acc_out),    64'd0);
    endtask

    // gap: 0 = in_valid held high, 1 = toggling 1/0, 2 = random.
    task automatic run_job(input logic [1:0] m, input int n, input int gap, input int hold,
                           input logic [63:0] e48, input logic o48,
                           input logic [63:0] e36, input logic o36);
        int   got;
        int   cyc;
        int   rdy_cyc;
        logic v;
        @(posedge clk); #1;
        start = 1'b1; mode = m; len = 16'(n);
        @(posedge clk); #1;
        start = 1'b0; mode = 2'($urandom); len = 16'($urandom);
        got = 0; cyc = 0; rdy_cyc = 0;
        while (got < n && cyc < 4000) begin
            v = (gap == 0) ? 1'b1 : (gap == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            in_valid = v;
            a = beat_a[got];
            b = beat_b[got];
            @(negedge clk);
            if (bus48.in_ready) rdy_cyc++;
            if (v && bus48.in_ready) got++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        a = '0;
        b = '0;
        chk("beats_accepted", 64'(got), 64'(n));
        if (gap == 0) chk("in_ready_cycles", 64'(rdy_cyc), 64'(n));
        if (n != 0) begin
            @(negedge clk);
            chk("drain_out_valid", 64'(bus48.out_valid), 64'd0);
            chk("drain_busy",      64'(busy48),          64'd1);
            @(posedge clk);
        end
        @(negedge clk);
        chk("done_out_valid",   64'(bus48.out_valid), 64'd1);
        chk("done_out_valid36", 64'(bus36.out_valid), 64'd1);
        chk("acc48",            64'(bus48.acc_out),   e48);
        chk("ovf48",            64'(bus48.overflow),  64'(o48));
        chk("acc36",            64'(bus36.acc_out),   e36);
        chk("ovf36",            64'(bus36.overflow),  64'(o36));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            start = (h == 1);
            len   = 16'd1;
            @(negedge clk);
            chk("hold_out_valid", 64'(bus48.out_valid), 64'd1);
            chk("hold_acc48",     64'(bus48.acc_out),   e48);
        end
        @(posedge clk); #1;
        start = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("idle_busy",      64'(busy48),          64'd0);
        chk("idle_out_valid", 64'(bus48.out_valid), 64'd0);
        chk("idle_acc_kept",  64'(bus48.acc_out),   e48);
    endtask

    task automatic load_pattern(input int n, input logic [63:0] pa, input logic [63:0] pb);
        beat_a.delete();
        beat_b.delete();
        for (int k = 0; k < n; k++) begin
            beat_a.push_back(pa);
            beat_b.push_back(pb);
        end
    endtask

    task automatic run_tbl(input int i);
        load_pattern(tbl[i].len, tbl[i].pa, tbl[i].pb);
        run_job(tbl[i].mode, tbl[i].len, tbl[i].gap, tbl[i].hold,
                tbl[i].e48, tbl[i].o48, tbl[i].e36, tbl[i].o36);
    endtask

    initial begin
        logic [63:0] ones;
        logic [63:0] tot;
        logic [1:0]  m;
        int          n;
        ones = '1;
        tbl[0] = '{2'd1, 1, {8{8'h01}}, {8{8'h01}}, 0, 0, 64'd8, 1'b0, 64'd8, 1'b0};
        tbl[1] = '{2'd0, 4, ones, ones, 0, 0, 64'hF_FFE0_0010, 1'b0, 64'hF_FFE0_0010, 1'b0};
        tbl[2] = '{2'd3, 3, ones, ones, 1, 0, 64'd864, 1'b0, 64'd864, 1'b0};
        tbl[3] = '{2'd0, 0, ones, ones, 0, 5, 64'd0, 1'b0, 64'd0, 1'b0};
`ifdef DP_SAT_EN
        tbl[4] = '{2'd0, 5, ones, ones, 0, 5, 64'h13_FFD8_0014, 1'b0, 64'hF_FFFF_FFFF, 1'b1};
`else
        tbl[4] = '{2'd0, 5, ones, ones, 0, 5, 64'h13_FFD8_0014, 1'b0, 64'h3_FFD8_0014, 1'b1};
`endif
        tbl[5] = '{2'd2, 1, {16{4'h1}}, {16{4'h1}}, 0, 0, 64'd16, 1'b0, 64'd16, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero_outputs("reset");
        @(posedge clk); #1;
        nrst = 1'b1;

        for (int i = 0; i < 5; i++) run_tbl(i);

        // Reset in the middle of an int16 job, after two of four beats.
        load_pattern(4, ones, ones);
        @(posedge clk); #1;
        start = 1'b1; mode = 2'd0; len = 16'd4;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1; a = ones; b = ones;
        repeat (2) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("prereset_busy", 64'(busy48),        64'd1);
        chk("prereset_acc",  64'(bus48.acc_out), 64'h7_FFF0_0008);
        #2 nrst = 1'b0;
        #1 chk_zero_outputs("midrun_reset");
        @(posedge clk); #1;
        nrst = 1'b1;
        run_tbl(5);

        // Randomized jobs against the lane-wise reference model.
        for (int j = 0; j < 25; j++) begin
            m = 2'($urandom_range(0, 3));
            n = $urandom_range(1, 40);
            beat_a.delete();
            beat_b.delete();
            tot = '0;
            for (int k = 0; k < n; k++) begin
                if (j % 4 == 0) begin
                    beat_a.push_back(ones);
                    beat_b.push_back(ones);
                end else begin
                    beat_a.push_back({$urandom, $urandom});
                    beat_b.push_back({$urandom, $urandom});
                end
                tot += lane_dot(m, beat_a[k], beat_b[k]);
            end
            run_job(m, n, $urandom_range(0, 2), (j % 3 == 0) ? 2 : 0,
                    exp_acc(tot, 48), exp_ovf(tot, 48), exp_acc(tot, 36), exp_ovf(tot, 36));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
